// File: rtl/mips_mem_pkg.sv
// Shared types and default widths for the unified instruction/data RAM port arbiter.
package mips_mem_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE,
        SERVE,
        DONE
    } state_t;

    typedef enum logic {
        GNT_MEM,
        GNT_IF
    } grant_t;

endpackage

// File: rtl/mem_port_arbiter_sat_counter.sv
// Counts consecutive MEM grants made while a fetch waits; sat tells the arbiter to let the fetch in.
module sat_counter #(
    parameter int MAX_CONSEC = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    logic [3:0] count;

    // Clear wins over increment; the count holds at 15 rather than wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= 4'd0;
        end else if (clr) begin
            count <= 4'd0;
        end else if (inc && (count != 4'hF)) begin
            count <= count + 4'd1;
        end
    end

    assign sat = (count >= 4'(MAX_CONSEC));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch port and the MEM-stage load/store port onto one single-ported RAM.
module mem_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int MAX_CONSEC = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              ram_req,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_ack,
    output logic              proto_err
);

    state_t state;
    grant_t grant;
    logic   mem_any;
    logic   sat;
    logic   grant_mem_now;
    logic   grant_if_now;
    logic   cnt_clr;

    assign mem_any = mem_rd | mem_wr;

    // MEM has priority unless the fetch has already waited out MAX_CONSEC MEM grants.
    assign grant_mem_now = (state == IDLE) && mem_any && (!sat || !if_req);
    assign grant_if_now  = (state == IDLE) && !grant_mem_now && if_req;
    assign cnt_clr       = (state == IDLE) && (grant_if_now || !if_req);

    sat_counter #(
        .MAX_CONSEC(MAX_CONSEC)
    ) u_consec (
        .clk(clk),
        .rst(rst),
        .inc(grant_mem_now),
        .clr(cnt_clr),
        .sat(sat)
    );

    assign stall_if  = if_req & ~if_ready;
    assign stall_mem = mem_any & ~mem_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            grant     <= GNT_MEM;
            ram_req   <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            if_rdata  <= '0;
            mem_rdata <= '0;
            if_ready  <= 1'b0;
            mem_ready <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            proto_err <= proto_err | (mem_rd & mem_wr);
            case (state)
                IDLE: begin
                    // A simultaneous rd+wr is executed as a write.
                    if (grant_mem_now) begin
                        grant     <= GNT_MEM;
                        ram_req   <= 1'b1;
                        ram_we    <= mem_wr;
                        ram_addr  <= mem_addr;
                        ram_wdata <= mem_wdata;
                        state     <= SERVE;
                    end else if (grant_if_now) begin
                        grant     <= GNT_IF;
                        ram_req   <= 1'b1;
                        ram_we    <= 1'b0;
                        ram_addr  <= if_addr;
                        ram_wdata <= '0;
                        state     <= SERVE;
                    end
                end
                SERVE: begin
                    if (ram_ack) begin
                        ram_req <= 1'b0;
                        ram_we  <= 1'b0;
                        if (grant == GNT_IF) begin
                            if_ready <= 1'b1;
                            if (!ram_we) if_rdata <= ram_rdata;
                        end else begin
                            mem_ready <= 1'b1;
                            if (!ram_we) mem_rdata <= ram_rdata;
                        end
                        state <= DONE;
                    end
                end
                DONE: begin
                    if_ready  <= 1'b0;
                    mem_ready <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
